memory_access: RTL

Memory-access (MA) stage of the five-stage MIPS pipeline, directly downstream of the execution stage. It consumes the EX/MA register contents (control, ALU result, store data, destination register), performs byte/halfword/word loads and stores on an internal word-organised data memory, and registers the MA/WB outputs for write-back. It also provides the MA forwarding taps back to execution and a read-only debug port for the debug unit.

---
 rtl/memory_access.sv | 131 +++++++++++++
 1 files changed

// File: rtl/memory_access.sv
// Memory-access stage of the five-stage MIPS pipeline.
// Byte/half/word loads and stores on a word-organised data memory, MA/WB
// pipeline registers, combinational forwarding taps and a debug read port.
// The byte-lane logic assumes a 32-bit data word, which gives four lanes.
module memory_access #(
    parameter int NB_DATA           = 32,
    parameter int NB_ADDR_REGISTERS = 5,
    parameter int NB_CONTROL_MA_WB  = 7,
    parameter int NB_CONTROL_WB     = 2,
    parameter int NB_MEM_ADDR       = 8
) (
    input  logic                         i_clk,
    input  logic                         i_reset,
    input  logic                         i_enable,
    input  logic [NB_CONTROL_MA_WB-1:0]  i_control_ma_wb,
    input  logic [NB_DATA-1:0]           i_result,
    input  logic [NB_DATA-1:0]           i_w_data_mem,
    input  logic [NB_ADDR_REGISTERS-1:0] i_rd_num,
    input  logic [NB_MEM_ADDR-1:0]       i_dbg_addr,
    output logic [NB_CONTROL_WB-1:0]     o_control_wb,
    output logic [NB_DATA-1:0]           o_read_data,
    output logic [NB_DATA-1:0]           o_result,
    output logic [NB_ADDR_REGISTERS-1:0] o_rd_num,
    output logic [NB_DATA-1:0]           o_ma_rd_data,
    output logic [NB_ADDR_REGISTERS-1:0] o_ma_rd_num,
    output logic                         o_ma_ctl_rw,
    output logic [NB_DATA-1:0]           o_dbg_data,
    output logic                         o_misaligned
);

    localparam int DEPTH    = 2 ** NB_MEM_ADDR;
    localparam int NB_LANES = 4;

    // Decoded control fields
    logic                   mem_read, mem_write, load_unsigned;
    logic [1:0]             size;
    logic [1:0]             lane;
    logic [NB_MEM_ADDR-1:0] word_idx;
    logic                   is_word, is_half;
    logic                   misaligned_now, write_en;

    logic [NB_DATA-1:0]     mem [DEPTH];
    logic [NB_DATA-1:0]     rd_word, load_data, read_next, store_data;
    logic [NB_LANES-1:0]    byte_en;
    logic [7:0]             sel_byte;
    logic [15:0]            sel_half;

    // Address bits above the memory size are ignored, so addresses wrap.
    logic                   unused_addr_bits;
    assign unused_addr_bits = ^i_result[NB_DATA-1:NB_MEM_ADDR+2];

    assign mem_read      = i_control_ma_wb[6];
    assign mem_write     = i_control_ma_wb[5];
    assign size          = i_control_ma_wb[4:3];
    assign load_unsigned = i_control_ma_wb[2];
    assign lane          = i_result[1:0];
    assign word_idx      = i_result[NB_MEM_ADDR+1:2];

    // Reserved size 2'b10 behaves as a word access.
    assign is_word = size[1];
    assign is_half = (size == 2'b01);

    assign misaligned_now = (mem_read || mem_write) &&
                            ((is_word && (lane != 2'b00)) || (is_half && lane[0]));
    assign write_en       = i_enable && mem_write && !misaligned_now;

    // Forwarding taps back to execution: no latency.
    assign o_ma_rd_data = i_result;
    assign o_ma_rd_num  = i_rd_num;
    assign o_ma_ctl_rw  = i_control_ma_wb[0];

    // Replicate store data across lanes and pick the lanes to update.
    always_comb begin
        store_data = i_w_data_mem;
        byte_en    = '1;
        if (is_half) begin
            store_data = {2{i_w_data_mem[15:0]}};
            byte_en    = lane[1] ? 4'b1100 : 4'b0011;
        end else if (!is_word) begin
            store_data = {NB_LANES{i_w_data_mem[7:0]}};
            byte_en    = 4'b0001 << lane;
        end
    end

    // Select the addressed byte/half and extend it to a full word.
    always_comb begin
        rd_word  = mem[word_idx];
        sel_byte = rd_word[{lane, 3'b000} +: 8];
        sel_half = lane[1] ? rd_word[31:16] : rd_word[15:0];
        if (is_word)
            load_data = rd_word;
        else if (is_half)
            load_data = {{(NB_DATA-16){~load_unsigned & sel_half[15]}}, sel_half};
        else
            load_data = {{(NB_DATA-8){~load_unsigned & sel_byte[7]}}, sel_byte};
        read_next = (mem_read && !mem_write && !misaligned_now) ? load_data : '0;
    end

    // Byte-masked store; contents survive reset, but a store is dropped while reset is low.
    always_ff @(posedge i_clk) begin
        if (i_reset && write_en) begin
            for (int b = 0; b < NB_LANES; b++) begin
                if (byte_en[b]) mem[word_idx][8*b +: 8] <= store_data[8*b +: 8];
            end
        end
    end

    // MA/WB pipeline registers and the sticky misalignment flag, frozen on stall.
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            o_control_wb <= '0;
            o_read_data  <= '0;
            o_result     <= '0;
            o_rd_num     <= '0;
            o_misaligned <= 1'b0;
        end else if (i_enable) begin
            o_control_wb <= i_control_ma_wb[NB_CONTROL_WB-1:0];
            o_read_data  <= read_next;
            o_result     <= i_result;
            o_rd_num     <= i_rd_num;
            if (misaligned_now) o_misaligned <= 1'b1;
        end
    end

    // Debug read runs every cycle and sees the pre-store word.
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) o_dbg_data <= '0;
        else          o_dbg_data <= mem[i_dbg_addr];
    end

endmodule
